quant_subtractor_pipe: RTL

//  Quantizer-side counterpart of the dequantizer adder stage. Each accepted sample has the

---
 rtl/quant_pkg.sv | 11 +
 rtl/quant_mag_sat.sv | 30 +++
 rtl/quant_subtractor_pipe.sv | 104 ++++++++++
 3 files changed

// File: rtl/quant_pkg.sv
// Shared quantizer/dequantizer defaults: datapath widths and the output code type.
package quant_pkg;

    localparam int WWIDTH   = 32;
    localparam int WWIDTH_H = 20;
    localparam int CODE_W   = 16;
    localparam int SHW      = 5;

    typedef logic [CODE_W-1:0] code_t;

endpackage

// File: rtl/quant_mag_sat.sv
// Combinational sign/magnitude split, step-exponent right shift and saturation to a code.
module quant_mag_sat #(
    parameter int W      = quant_pkg::WWIDTH,
    parameter int CODE_W = quant_pkg::CODE_W,
    parameter int SHW    = quant_pkg::SHW
) (
    input  logic [W-1:0]      diff,
    input  logic [SHW-1:0]    shift,
    output logic [CODE_W-1:0] code,
    output logic              sign,
    output logic              sat
);

    logic [W-1:0] mag;
    logic [W-1:0] q;
    logic [W:0]   q_ext;
    logic [W:0]   code_lim;

    assign sign = diff[W-1];
    // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude.
    assign mag  = sign ? (~diff + W'(1)) : diff;
    // A logical shift by W or more already yields zero.
    assign q    = mag >> shift;

    assign q_ext    = {1'b0, q};
    assign code_lim = (W + 1)'(1) << CODE_W;
    assign sat      = (q_ext >= code_lim);
    assign code     = sat ? '1 : q[CODE_W-1:0];

endmodule

// File: rtl/quant_subtractor_pipe.sv
// Three-stage quantizer front end: split subtract with registered carry, then abs/shift/saturate.
module quant_subtractor_pipe #(
    parameter int WWIDTH   = quant_pkg::WWIDTH,
    parameter int WWIDTH_H = quant_pkg::WWIDTH_H,
    parameter int CODE_W   = quant_pkg::CODE_W,
    parameter int SHW      = quant_pkg::SHW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WWIDTH-1:0] Sample,
    input  logic [WWIDTH-1:0] Mid,
    input  logic [SHW-1:0]    shift,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code,
    output logic              sign,
    output logic              sat
);

    localparam int H  = WWIDTH_H;
    localparam int HI = WWIDTH - WWIDTH_H;

    logic adv;

    logic          v1;
    logic [H:0]    lo_r;
    logic [HI-1:0] s_hi_r;
    logic [HI-1:0] nm_hi_r;
    logic [SHW-1:0] sh1_r;

    logic              v2;
    logic [WWIDTH-1:0] diff_r;
    logic [SHW-1:0]    sh2_r;

    logic [H:0]        lo_nxt;
    logic [HI-1:0]     hi_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic              sign_nxt;
    logic              sat_nxt;

    // Whole pipe advances together; a stalled output freezes every stage.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign lo_nxt = {1'b0, Sample[H-1:0]} + {1'b0, ~Mid[H-1:0]} + (H + 1)'(1);
    assign hi_nxt = s_hi_r + nm_hi_r + HI'(lo_r[H]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            lo_r    <= '0;
            s_hi_r  <= '0;
            nm_hi_r <= '0;
            sh1_r   <= '0;
        end else if (adv) begin
            v1      <= in_valid;
            lo_r    <= lo_nxt;
            s_hi_r  <= Sample[WWIDTH-1:H];
            nm_hi_r <= ~Mid[WWIDTH-1:H];
            sh1_r   <= shift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2     <= 1'b0;
            diff_r <= '0;
            sh2_r  <= '0;
        end else if (adv) begin
            v2     <= v1;
            diff_r <= {hi_nxt, lo_r[H-1:0]};
            sh2_r  <= sh1_r;
        end
    end

    quant_mag_sat #(
        .W      (WWIDTH),
        .CODE_W (CODE_W),
        .SHW    (SHW)
    ) u_mag_sat (
        .diff  (diff_r),
        .shift (sh2_r),
        .code  (code_nxt),
        .sign  (sign_nxt),
        .sat   (sat_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            code      <= '0;
            sign      <= 1'b0;
            sat       <= 1'b0;
        end else if (adv) begin
            out_valid <= v2;
            code      <= code_nxt;
            sign      <= sign_nxt;
            sat       <= sat_nxt;
        end
    end

endmodule
